// File: rtl/ram_ctrl_pkg.sv
// Shared encodings for the RAM controller: FSM state values and read-client indices.
package ram_ctrl_pkg;

  localparam logic ST_CLEAR = 1'b0;
  localparam logic ST_RUN   = 1'b1;

  localparam logic RD0 = 1'b0;
  localparam logic RD1 = 1'b1;

endpackage

// File: rtl/ram_ctrl_ram.sv
// Simple dual-port block RAM: one write port, one registered read port, one clock.
// Reads see the contents from before a same-edge write (read-first).
module ram_ctrl_ram #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int WORDS      = 4096
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [0:WORDS-1];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/ram_ctrl.sv
// Block-RAM owner: zero-fills after reset / on clr_req, gates one writer and arbitrates
// two readers round-robin. Define RAM_CTRL_READ_BYPASS_EN for write-to-read forwarding.
module ram_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int WORDS      = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_req,
  output logic                  clr_busy,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd0_valid,
  output logic                  rd0_ready,
  input  logic [ADDR_WIDTH-1:0] rd0_addr,
  output logic                  rd0_rvalid,
  output logic [DATA_WIDTH-1:0] rd0_rdata,
  input  logic                  rd1_valid,
  output logic                  rd1_ready,
  input  logic [ADDR_WIDTH-1:0] rd1_addr,
  output logic                  rd1_rvalid,
  output logic [DATA_WIDTH-1:0] rd1_rdata
);

  logic                  state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  rr_last_q, rr_last_d;
  logic                  rd0_rvalid_q, rd1_rvalid_q;
  logic [DATA_WIDTH-1:0] rd0_hold_q, rd1_hold_q;

  logic                  clr_last;
  logic                  run_open;
  logic                  gnt0, gnt1;
  logic                  wr_fire, rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic [DATA_WIDTH-1:0] rd_resp;

  assign clr_last = (clr_cnt_q == ADDR_WIDTH'(WORDS - 1));
  assign run_open = (state_q == ST_RUN) && !clr_req;

  // Lone requester wins; on a tie the client that did not win last time goes.
  assign gnt0 = rd0_valid && (!rd1_valid || rr_last_q == RD1);
  assign gnt1 = rd1_valid && (!rd0_valid || rr_last_q == RD0);

  assign wr_fire = wr_valid && wr_ready;
  assign rd_en   = rd0_ready || rd1_ready;
  assign rd_addr = rd1_ready ? rd1_addr : rd0_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_CLEAR;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR: if (clr_last) state_d = ST_RUN;
      ST_RUN:   if (clr_req)  state_d = ST_CLEAR;
      default:  state_d = ST_CLEAR;
    endcase
  end

  always_comb begin
    clr_busy  = (state_q == ST_CLEAR);
    wr_ready  = run_open;
    rd0_ready = run_open && gnt0;
    rd1_ready = run_open && gnt1;
    ram_we    = clr_busy ? 1'b1      : wr_fire;
    ram_waddr = clr_busy ? clr_cnt_q : wr_addr;
    ram_wdata = clr_busy ? '0        : wr_data;
  end

  always_comb begin
    clr_cnt_d = '0;
    if (state_q == ST_CLEAR && !clr_last) clr_cnt_d = clr_cnt_q + 1'b1;
    rr_last_d = rr_last_q;
    if (rd1_ready)      rr_last_d = RD1;
    else if (rd0_ready) rr_last_d = RD0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt_q    <= '0;
      rr_last_q    <= RD1;
      rd0_rvalid_q <= 1'b0;
      rd1_rvalid_q <= 1'b0;
      rd0_hold_q   <= '0;
      rd1_hold_q   <= '0;
    end else begin
      clr_cnt_q    <= clr_cnt_d;
      rr_last_q    <= rr_last_d;
      rd0_rvalid_q <= rd0_ready;
      rd1_rvalid_q <= rd1_ready;
      if (rd0_rvalid_q) rd0_hold_q <= rd_resp;
      if (rd1_rvalid_q) rd1_hold_q <= rd_resp;
    end
  end

`ifdef RAM_CTRL_READ_BYPASS_EN
  logic                  byp_hit_q;
  logic [DATA_WIDTH-1:0] byp_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_hit_q  <= 1'b0;
      byp_data_q <= '0;
    end else begin
      byp_hit_q  <= wr_fire && rd_en && (wr_addr == rd_addr);
      byp_data_q <= wr_data;
    end
  end

  assign rd_resp = byp_hit_q ? byp_data_q : ram_rdata;
`else
  assign rd_resp = ram_rdata;
`endif

  // The response is live from the RAM in its pulse cycle, then held per client.
  assign rd0_rvalid = rd0_rvalid_q;
  assign rd1_rvalid = rd1_rvalid_q;
  assign rd0_rdata  = rd0_rvalid_q ? rd_resp : rd0_hold_q;
  assign rd1_rdata  = rd1_rvalid_q ? rd_resp : rd1_hold_q;

  ram_ctrl_ram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .WORDS     (WORDS)
  ) u_ram (
    .clk    (clk),
    .we_i   (ram_we),
    .waddr_i(ram_waddr),
    .wdata_i(ram_wdata),
    .re_i   (rd_en),
    .raddr_i(rd_addr),
    .rdata_o(ram_rdata)
  );

endmodule
